// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a scanned 7-segment bus (segments + one-hot anodes),
// waits for each digit's dwell to settle, decodes the pattern back to BCD and
// assembles a full multi-digit frame with a one-cycle completion pulse.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_valid
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7:0]              r_seg_s;
  logic [NUM_DIGITS-1:0]   r_an_s;
  logic [7:0]              r_seg_p;
  logic [NUM_DIGITS-1:0]   r_an_p;
  logic [CW-1:0]           r_cnt;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_fv;

  logic                    w_diff;
  logic                    w_onehot;
  logic [CW-1:0]           w_run;
  logic                    w_settled;
  logic                    w_capture;
  logic [3:0]              w_dec_bcd;
  logic                    w_dec_err;
  logic [NUM_DIGITS-1:0]   w_mask_nxt;

  assign bcd_out     = r_bcd;
  assign dp_out      = r_dp;
  assign err_out     = r_err;
  assign frame_valid = r_fv;

  assign w_diff     = (r_seg_s != r_seg_p) || (r_an_s != r_an_p);
  assign w_onehot   = $onehot(r_an_s);
  assign w_settled  = (w_run == SETTLE_MAX);
  assign w_mask_nxt = r_mask | r_an_s;

  // Input sample stage plus previous-sample copy used for stability detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_s <= '0;
      r_an_s  <= '0;
      r_seg_p <= '0;
      r_an_p  <= '0;
    end else begin
      r_seg_s <= seg_in;
      r_an_s  <= an_in;
      r_seg_p <= r_seg_s;
      r_an_p  <= r_an_s;
    end
  end

  // Run length of identical samples including the current one, saturating.
  // Capture fires when the run reaches SETTLE_CYCLES, so a value first sampled
  // at edge E0 is captured at edge E0+SETTLE_CYCLES.
  always_comb begin
    w_run = r_cnt;
    if (w_diff) begin
      w_run = CW'(1);
    end else if (r_cnt != SETTLE_MAX) begin
      w_run = r_cnt + 1'b1;
    end
  end

  // Stability counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_run;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = w_settled ? CAPTURED : SETTLE;
        end
      end
      SETTLE: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
        end else if (w_settled) begin
          w_state_nxt = CAPTURED;
        end
      end
      CAPTURED: begin
        if (w_diff) begin
          if (!w_onehot) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = w_settled ? CAPTURED : SETTLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output: capture strobe; CAPTURED only recaptures on a fresh sample
  always_comb begin
    w_capture = 1'b0;
    case (r_state)
      IDLE, SETTLE: w_capture = w_onehot && w_settled;
      CAPTURED:     w_capture = w_diff && w_onehot && w_settled;
      default:      w_capture = 1'b0;
    endcase
  end

  // Segment pattern (abcdefg) to BCD; blank is legal, anything else is an error
  always_comb begin
    w_dec_bcd = 4'hF;
    w_dec_err = 1'b0;
    case (r_seg_s[7:1])
      7'b1111110: w_dec_bcd = 4'd0;
      7'b0110000: w_dec_bcd = 4'd1;
      7'b1101101: w_dec_bcd = 4'd2;
      7'b1111001: w_dec_bcd = 4'd3;
      7'b0110011: w_dec_bcd = 4'd4;
      7'b1011011: w_dec_bcd = 4'd5;
      7'b1011111: w_dec_bcd = 4'd6;
      7'b1110000: w_dec_bcd = 4'd7;
      7'b1111111: w_dec_bcd = 4'd8;
      7'b1111011: w_dec_bcd = 4'd9;
      7'b0000000: w_dec_bcd = 4'hF;
      default:    w_dec_err = 1'b1;
    endcase
  end

  // Digit capture, frame mask and frame-complete pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd  <= '1;
      r_dp   <= '0;
      r_err  <= '0;
      r_mask <= '0;
      r_fv   <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      if (w_capture) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (r_an_s[i]) begin
            r_bcd[4*i +: 4] <= w_dec_bcd;
            r_dp[i]         <= r_seg_s[0];
            r_err[i]        <= w_dec_err;
          end
        end
        if (w_mask_nxt == '1) begin
          r_fv   <= 1'b1;
          r_mask <= '0;
        end else begin
          r_mask <= w_mask_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (4 digits, 4-sample settle).
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic [3:0]  err_out;
  logic        frame_valid;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .err_out     (err_out),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive an/seg at a falling edge, hold for n cycles. Reports number of
  // frame_valid pulses, cycle of the first pulse and cycle of the first
  // bcd_out change (1 = first falling edge after the drive; 0 = never).
  task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int n,
                       output int fv_cnt, output int fv_at, output int chg_at);
    logic [15:0] prev;
    prev   = bcd_out;
    fv_cnt = 0;
    fv_at  = 0;
    chg_at = 0;
    an_in  = an;
    seg_in = seg;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (frame_valid) begin
        fv_cnt++;
        if (fv_at == 0) fv_at = c;
      end
      if (chg_at == 0 && bcd_out !== prev) chg_at = c;
    end
  endtask

  int fv, fva, chg, fv_tot;
  logic [15:0] save_bcd;
  logic [3:0]  save_dp, save_err;

  initial begin
    rst    = 1'b1;
    an_in  = '0;
    seg_in = '0;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0000_FFFF);
    check("rst_dp",  32'(dp_out), 32'h0);
    check("rst_err", 32'(err_out), 32'h0);
    check("rst_fv",  32'(frame_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 2: full scan 1,2,3,4
    fv_tot = 0;
    dwell(4'b0001, 8'h60, 8, fv, fva, chg); fv_tot += fv;
    check("scan_d0_lat", 32'(chg), 32'd5);
    dwell(4'b0010, 8'hDA, 8, fv, fva, chg); fv_tot += fv;
    dwell(4'b0100, 8'hF2, 8, fv, fva, chg); fv_tot += fv;
    dwell(4'b1000, 8'h66, 8, fv, fva, chg); fv_tot += fv;
    check("scan_fv_at",  32'(fva), 32'd5);
    check("scan_d3_chg", 32'(chg), 32'd5);
    check("scan_fv_cnt", 32'(fv_tot), 32'd1);
    check("scan_bcd",    32'(bcd_out), 32'h0000_4321);
    check("scan_err",    32'(err_out), 32'h0);

    // 3: short glitch then real value on digit0
    dwell(4'b0001, 8'hFC, 3, fv, fva, chg);
    check("glitch_nochg", 32'(chg), 32'd0);
    dwell(4'b0001, 8'hB6, 8, fv, fva, chg);
    check("glitch_lat", 32'(chg), 32'd5);
    check("glitch_bcd", 32'(bcd_out), 32'h0000_4325);
    check("glitch_fv",  32'(fv), 32'd0);

    // 4: patterns on digit1
    dwell(4'b0010, 8'hFD, 8, fv, fva, chg);
    check("p0_bcd", 32'(bcd_out), 32'h0000_4305);
    check("p0_dp",  32'(dp_out), 32'b0010);
    dwell(4'b0010, 8'h00, 8, fv, fva, chg);
    check("blank_bcd", 32'(bcd_out), 32'h0000_43F5);
    check("blank_err", 32'(err_out), 32'h0);
    check("blank_dp",  32'(dp_out), 32'h0);
    dwell(4'b0010, 8'h80, 8, fv, fva, chg);
    check("bad_bcd", 32'(bcd_out), 32'h0000_43F5);
    check("bad_err", 32'(err_out), 32'b0010);

    // 5: anode not one-hot -> nothing captured
    save_bcd = bcd_out;
    save_dp  = dp_out;
    save_err = err_out;
    dwell(4'b0011, 8'h60, 20, fv, fva, chg);
    check("multi_bcd", 32'(bcd_out), 32'(save_bcd));
    check("multi_fv",  32'(fv), 32'd0);
    check("multi_err", 32'(err_out), 32'(save_err));
    dwell(4'b0000, 8'hDA, 20, fv, fva, chg);
    check("none_bcd", 32'(bcd_out), 32'(save_bcd));
    check("none_dp",  32'(dp_out), 32'(save_dp));
    check("none_fv",  32'(fv), 32'd0);

    // 6: partial frame, reset, then full post-reset scan 7,8,9,0
    fv_tot = 0;
    dwell(4'b0001, 8'h60, 8, fv, fva, chg); fv_tot += fv;
    dwell(4'b0010, 8'hDA, 8, fv, fva, chg); fv_tot += fv;
    check("pre_fv", 32'(fv_tot), 32'd0);
    check("pre_bcd", 32'(bcd_out), 32'h0000_4321);
    an_in  = '0;
    seg_in = '0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_bcd", 32'(bcd_out), 32'h0000_FFFF);
    check("rst2_err", 32'(err_out), 32'h0);
    check("rst2_fv",  32'(frame_valid), 32'h0);
    fv_tot = 0;
    dwell(4'b0001, 8'hE0, 8, fv, fva, chg); fv_tot += fv;
    dwell(4'b0010, 8'hFE, 8, fv, fva, chg); fv_tot += fv;
    dwell(4'b0100, 8'hF6, 8, fv, fva, chg); fv_tot += fv;
    check("post_fv_early", 32'(fv_tot), 32'd0);
    dwell(4'b1000, 8'hFC, 8, fv, fva, chg); fv_tot += fv;
    check("post_fv_cnt", 32'(fv_tot), 32'd1);
    check("post_fv_at",  32'(fva), 32'd5);
    check("post_bcd",    32'(bcd_out), 32'h0000_0987);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
